mux4_rr_arbiter: RTL and testbench



---
 rtl/mux4_rr_arbiter_pkg.sv | 14 +
 rtl/mux4_rr_arbiter_mux4_w.sv | 21 ++
 rtl/mux4_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared types and sizes for the 4-way round-robin arbiter and its 4:1 data mux.
package mux4_rr_arbiter_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/mux4_rr_arbiter_mux4_w.sv
// Parameterized 4:1 mux built as a tree of three 2:1 stages (s0 picks within a pair, s1 picks the pair).
module mux4_w #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] i0,
    input  logic [DATA_W-1:0] i1,
    input  logic [DATA_W-1:0] i2,
    input  logic [DATA_W-1:0] i3,
    input  logic              s0,
    input  logic              s1,
    output logic [DATA_W-1:0] y
);

    logic [DATA_W-1:0] lo_pair;
    logic [DATA_W-1:0] hi_pair;

    assign lo_pair = s0 ? i1 : i0;
    assign hi_pair = s0 ? i3 : i2;
    assign y       = s1 ? hi_pair : lo_pair;

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready output channel between 4 requesters,
// with an optional per-grant beat limit and a registered mux select.
module mux4_rr_arbiter
    import mux4_rr_arbiter_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] i0,
    input  logic [DATA_W-1:0] i1,
    input  logic [DATA_W-1:0] i2,
    input  logic [DATA_W-1:0] i3,
    input  logic              out_ready,
    output logic [3:0]        gnt,
    output logic              s1,
    output logic              s0,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    localparam logic [7:0] BURST_LAST = (MAX_BURST == 0) ? 8'd0 : 8'(MAX_BURST - 1);

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    sel_t       sel_q, sel_d;
    sel_t       last_ptr_q, last_ptr_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;

    sel_t winner;
    logic found;
    logic xfer;
    logic burst_done;

    // Search starts just after the last winner, so the last winner is checked last.
    always_comb begin
        sel_t cand;
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = last_ptr_q + sel_t'(k);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign out_valid  = (state_q == ST_GRANT) && req[sel_q];
    assign xfer       = out_valid && out_ready;
    assign burst_done = (MAX_BURST != 0) && xfer && (beat_cnt_q == BURST_LAST);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        sel_d      = sel_q;
        last_ptr_d = last_ptr_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d    = ST_GRANT;
                    gnt_d      = 4'b0001 << winner;
                    sel_d      = winner;
                    last_ptr_d = winner;
                    beat_cnt_d = 8'd0;
                end
            end
            ST_GRANT: begin
                // A release always passes through one IDLE cycle before the next grant.
                if (!req[sel_q] || burst_done) begin
                    state_d = ST_IDLE;
                    gnt_d   = 4'b0000;
                    sel_d   = '0;
                end else if (xfer) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 4'b0000;
                sel_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 4'b0000;
            sel_q      <= '0;
            last_ptr_q <= sel_t'(N_REQ - 1);
            beat_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            sel_q      <= sel_d;
            last_ptr_q <= last_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign gnt  = gnt_q;
    assign s1   = sel_q[1];
    assign s0   = sel_q[0];
    assign busy = (state_q == ST_GRANT);

    mux4_w #(
        .DATA_W(DATA_W)
    ) u_data_mux (
        .i0(i0),
        .i1(i1),
        .i2(i2),
        .i3(i3),
        .s0(sel_q[0]),
        .s1(sel_q[1]),
        .y (out_data)
    );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Drives three arbiters (burst limits 4, 2 and unlimited) with shared stimulus and
// compares every output each cycle against a per-instance behavioural model.
module tb_mux4_rr_arbiter;

    localparam int DATA_W = 8;
    localparam int N_DUT  = 3;
    localparam int MB [N_DUT] = '{4, 2, 0};

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        req;
    logic [DATA_W-1:0] i0, i1, i2, i3;
    logic              out_ready;

    logic [3:0]        gnt_o   [N_DUT];
    logic              s1_o    [N_DUT];
    logic              s0_o    [N_DUT];
    logic              valid_o [N_DUT];
    logic [DATA_W-1:0] data_o  [N_DUT];
    logic              busy_o  [N_DUT];

    bit mBusy [N_DUT];
    int mG    [N_DUT];
    int mLast [N_DUT];
    int mCnt  [N_DUT];

    int   testCount;
    int   failCount;
    logic forceA5;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N_DUT; gi++) begin : g_dut
        mux4_rr_arbiter #(
            .DATA_W   (DATA_W),
            .MAX_BURST((gi == 0) ? 4 : (gi == 1) ? 2 : 0)
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .req      (req),
            .i0       (i0),
            .i1       (i1),
            .i2       (i2),
            .i3       (i3),
            .out_ready(out_ready),
            .gnt      (gnt_o[gi]),
            .s1       (s1_o[gi]),
            .s0       (s0_o[gi]),
            .out_valid(valid_o[gi]),
            .out_data (data_o[gi]),
            .busy     (busy_o[gi])
        );
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void resetModels();
        for (int n = 0; n < N_DUT; n++) begin
            mBusy[n] = 1'b0;
            mG[n]    = 0;
            mLast[n] = 3;
            mCnt[n]  = 0;
        end
    endfunction

    // One clock edge of the arbitration rules, applied to the inputs present at that edge.
    task automatic stepModels();
        if (!rst_n) begin
            resetModels();
            return;
        end
        for (int n = 0; n < N_DUT; n++) begin
            if (!mBusy[n]) begin
                for (int k = 1; k <= 4; k++) begin
                    int c = (mLast[n] + k) % 4;
                    if (req[c]) begin
                        mBusy[n] = 1'b1;
                        mG[n]    = c;
                        mLast[n] = c;
                        mCnt[n]  = 0;
                        break;
                    end
                end
            end else begin
                bit moved = req[mG[n]] && out_ready;
                if (!req[mG[n]]) begin
                    mBusy[n] = 1'b0;
                end else if (MB[n] != 0 && moved && (mCnt[n] + 1 == MB[n])) begin
                    mBusy[n] = 1'b0;
                end else if (moved) begin
                    mCnt[n] = mCnt[n] + 1;
                end
            end
        end
    endtask

    task automatic compareAll(input string where);
        logic [DATA_W-1:0] din [4];
        din[0] = i0; din[1] = i1; din[2] = i2; din[3] = i3;
        for (int n = 0; n < N_DUT; n++) begin
            int  eSel   = mBusy[n] ? mG[n] : 0;
            int  eGnt   = mBusy[n] ? (1 << mG[n]) : 0;
            bit  eValid = mBusy[n] && req[mG[n]];
            checkOutput($sformatf("%s.gnt[%0d]", where, n), 32'(gnt_o[n]), 32'(eGnt));
            checkOutput($sformatf("%s.sel[%0d]", where, n), 32'({s1_o[n], s0_o[n]}), 32'(eSel));
            checkOutput($sformatf("%s.valid[%0d]", where, n), 32'(valid_o[n]), 32'(eValid));
            checkOutput($sformatf("%s.busy[%0d]", where, n), 32'(busy_o[n]), 32'(mBusy[n]));
            checkOutput($sformatf("%s.data[%0d]", where, n), 32'(data_o[n]), 32'(din[eSel]));
        end
    endtask

    // Advance one clock, then drive new inputs at the falling edge and check just after.
    task automatic applyStimulus(input logic [3:0] r, input logic rdy);
        @(posedge clk);
        stepModels();
        @(negedge clk);
        req       = r;
        out_ready = rdy;
        i0        = 8'($urandom);
        i1        = 8'($urandom);
        i2        = forceA5 ? 8'hA5 : 8'($urandom);
        i3        = 8'($urandom);
        #1;
        compareAll("cyc");
    endtask

    // Short asynchronous reset pulse entirely between clock edges.
    task automatic rstPulse();
        rst_n = 1'b0;
        #1;
        resetModels();
        compareAll("rst");
        for (int n = 0; n < N_DUT; n++) begin
            checkOutput($sformatf("async_gnt[%0d]", n), 32'(gnt_o[n]), 32'd0);
            checkOutput($sformatf("async_busy[%0d]", n), 32'(busy_o[n]), 32'd0);
            checkOutput($sformatf("async_valid[%0d]", n), 32'(valid_o[n]), 32'd0);
        end
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int          q [$];
        int          beats;
        int          idleRun;
        bit          prevBusy;
        bit          started;
        logic [3:0]  r;
        logic        rdy;
        int          order [5];

        testCount = 0;
        failCount = 0;
        forceA5   = 1'b0;
        rst_n     = 1'b0;
        req       = 4'b1111;
        out_ready = 1'b1;
        i0 = '0; i1 = '0; i2 = '0; i3 = '0;
        resetModels();

        // Reset held with all requests up, then release: requester 0 wins first.
        applyStimulus(4'b1111, 1'b1);
        applyStimulus(4'b1111, 1'b1);
        #1 rst_n = 1'b1;
        applyStimulus(4'b1111, 1'b1);
        checkOutput("first_gnt", 32'(gnt_o[0]), 32'h1);
        checkOutput("first_valid", 32'(valid_o[0]), 32'h1);
        checkOutput("first_data", 32'(data_o[0]), 32'(i0));

        // Lone requester 2 with constant data: bursts of 4, one idle cycle between.
        forceA5 = 1'b1;
        applyStimulus(4'b0100, 1'b1);
        rstPulse();
        prevBusy = 1'b0; started = 1'b0; beats = 0; idleRun = 0;
        for (int c = 0; c < 22; c++) begin
            applyStimulus(4'b0100, 1'b1);
            if (busy_o[0]) begin
                if (!prevBusy && started) checkOutput("idle_len", 32'(idleRun), 32'd1);
                if (valid_o[0]) begin
                    beats++;
                    checkOutput("a5_data", 32'(data_o[0]), 32'hA5);
                end
            end else begin
                if (prevBusy) begin
                    checkOutput("burst_len", 32'(beats), 32'd4);
                    beats = 0; started = 1'b1; idleRun = 0;
                end
                idleRun++;
            end
            prevBusy = busy_o[0];
        end
        forceA5 = 1'b0;

        // All requesting: grant order 0,1,2,3,0.
        applyStimulus(4'b1111, 1'b1);
        rstPulse();
        prevBusy = 1'b0;
        for (int c = 0; c < 30; c++) begin
            applyStimulus(4'b1111, 1'b1);
            if (busy_o[0] && !prevBusy) q.push_back(int'({s1_o[0], s0_o[0]}));
            prevBusy = busy_o[0];
        end
        order = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++)
            checkOutput($sformatf("order[%0d]", k), 32'((k < q.size()) ? q[k] : 99), 32'(order[k]));

        // Requester 1 drops its request while the consumer stalls.
        applyStimulus(4'b0010, 1'b1);
        rstPulse();
        applyStimulus(4'b0010, 1'b1);
        checkOutput("r1_gnt", 32'(gnt_o[0]), 32'h2);
        applyStimulus(4'b0010, 1'b1);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("drop_valid", 32'(valid_o[0]), 32'd0);
        applyStimulus(4'b0000, 1'b0);
        checkOutput("drop_gnt", 32'(gnt_o[0]), 32'd0);
        applyStimulus(4'b0010, 1'b1);
        applyStimulus(4'b0010, 1'b1);

        // Toggling ready with a limit of 2: stalled cycles are not counted.
        applyStimulus(4'b0001, 1'b1);
        rstPulse();
        applyStimulus(4'b0001, 1'b1);
        applyStimulus(4'b0001, 1'b0);
        applyStimulus(4'b0001, 1'b1);
        applyStimulus(4'b0001, 1'b0);
        checkOutput("mb2_release", 32'(gnt_o[1]), 32'd0);
        checkOutput("mb4_held", 32'(gnt_o[0]), 32'h1);
        checkOutput("mb0_held", 32'(gnt_o[2]), 32'h1);

        // Reset mid-burst on requester 3; requester 0 wins afterwards.
        applyStimulus(4'b1000, 1'b1);
        rstPulse();
        applyStimulus(4'b1000, 1'b1);
        applyStimulus(4'b1001, 1'b1);
        checkOutput("r3_gnt", 32'(gnt_o[0]), 32'h8);
        rstPulse();
        applyStimulus(4'b1001, 1'b1);
        checkOutput("post_rst_gnt", 32'(gnt_o[0]), 32'h1);

        // Randomized traffic with sticky requests and occasional resets.
        r = req;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(5) == 0) r[b] = ~r[b];
            rdy = ($urandom_range(3) != 0);
            applyStimulus(r, rdy);
            if ($urandom_range(299) == 0) rstPulse();
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
